// File: rtl/twiddle_pkg.sv
// Shared types and Q1.(W-1) fixed-point helpers for the twiddle sequencer.
// Includes the elaboration-time integer cosine used to fill the quarter-wave ROM.
package twiddle_pkg;

    localparam int FX_W = 18;
    typedef logic signed [FX_W-1:0] fx_t;

    typedef enum logic [1:0] {QD0, QD1, QD2, QD3} quadrant_t;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    // pi scaled by 2**30
    localparam longint PI_FX = 64'sd3373259426;

    function automatic fx_t fx_max(int w);
        return fx_t'((1 << (w - 1)) - 1);
    endfunction

    function automatic fx_t fx_min(int w);
        return -fx_t'(1 << (w - 1));
    endfunction

    // MAX and MIN map onto each other so that +1/-1 round-trip through saturation
    function automatic fx_t fx_neg(fx_t x, int w);
        if (x == fx_max(w)) return fx_min(w);
        if (x == fx_min(w)) return fx_max(w);
        return -x;
    endfunction

    // round(cos(pi/2 * x/q) * 2**(w-1)), saturated to MAX; Taylor series in 2**30 fixed point
    function automatic fx_t cos_q(int x, int q, int w);
        longint th, th2, term, sum, v;
        th   = (PI_FX * longint'(x)) / longint'(2 * q);
        th2  = (th * th) >>> 30;
        term = 64'sd1 <<< 30;
        sum  = term;
        for (int n = 0; n < 14; n++) begin
            term = -((term * th2) >>> 30) / longint'((2 * n + 1) * (2 * n + 2));
            sum  = sum + term;
        end
        v = (sum * (64'sd1 <<< (w - 1)) + (64'sd1 <<< 29)) >>> 30;
        if (v > (64'sd1 <<< (w - 1)) - 1) v = (64'sd1 <<< (w - 1)) - 1;
        if (v < 0) v = 0;
        return fx_t'(v);
    endfunction

endpackage

// File: rtl/twiddle_rom.sv
// Quarter-wave cosine table, N/4+1 entries built at elaboration,
// with two registered read ports that only advance when enabled.
module twiddle_rom
    import twiddle_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LOG2N = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [LOG2N-2:0] addr_a,
    input  logic [LOG2N-2:0] addr_b,
    output logic [WIDTH-1:0] data_a,
    output logic [WIDTH-1:0] data_b
);

    localparam int Q = (1 << LOG2N) / 4;

    logic [WIDTH-1:0] table_c [0:Q];

    for (genvar x = 0; x <= Q; x++) begin : g_tab
        localparam logic [WIDTH-1:0] V = WIDTH'(cos_q(x, Q, WIDTH));
        assign table_c[x] = V;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_a <= '0;
            data_b <= '0;
        end else if (en) begin
            data_a <= table_c[addr_a];
            data_b <= table_c[addr_b];
        end
    end

endmodule

// File: rtl/twiddle_seq_gen.sv
// Streams radix-2 DIT twiddles W_N^k in butterfly order over a valid/ready port.
// Optional TWIDDLE_CONJ_EN adds an `inverse` input that conjugates the twiddles.
module twiddle_seq_gen
    import twiddle_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LOG2N = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         Rtw,
    output logic [WIDTH-1:0]         Itw,
    output logic [$clog2(LOG2N)-1:0] stage,
    output logic [LOG2N-1:0]         k,
    output logic                     last
`ifdef TWIDDLE_CONJ_EN
    ,
    input  logic                     inverse
`endif
);

    localparam int N      = 1 << LOG2N;
    localparam int HALF   = N / 2;
    localparam int Q      = N / 4;
    localparam int SW     = $clog2(LOG2N);
    localparam int IW     = LOG2N - 1;
    localparam int STAGES = 2;

    state_t             state, state_n;
    logic               adv, accept, issue, issue_last, inv_r;
    logic [SW-1:0]      s_cnt, s1;
    logic [IW-1:0]      b_cnt, m_idx, mc_idx;
    logic [LOG2N-1:0]   b_ext, mask, k_iss, k1;
    logic               last1;
    logic [STAGES:1]    vld_pipe;
    logic [WIDTH-1:0]   c_m, c_mc, r_n, i_n;

    function automatic logic [WIDTH-1:0] neg_w(logic [WIDTH-1:0] x);
        return WIDTH'(fx_neg(fx_t'($signed(x)), WIDTH));
    endfunction

    // Whole pipeline, counters included, moves only when the output slot is free
    assign adv        = !out_valid || out_ready;
    assign accept     = (state == IDLE) && start;
    assign issue      = (state == RUN) && adv;
    assign issue_last = (s_cnt == SW'(LOG2N - 1)) && (b_cnt == IW'(HALF - 1));
    assign busy       = (state != IDLE);
    assign out_valid  = vld_pipe[STAGES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = RUN;
            RUN:     if (issue && issue_last) state_n = DRAIN;
            DRAIN:   if (out_valid && out_ready && last) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_cnt <= '0;
            b_cnt <= '0;
        end else if (accept) begin
            s_cnt <= '0;
            b_cnt <= '0;
        end else if (issue) begin
            if (b_cnt == IW'(HALF - 1)) begin
                b_cnt <= '0;
                s_cnt <= issue_last ? '0 : s_cnt + 1'b1;
            end else begin
                b_cnt <= b_cnt + 1'b1;
            end
        end
    end

`ifdef TWIDDLE_CONJ_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         inv_r <= 1'b0;
        else if (accept) inv_r <= inverse;
    end
`else
    assign inv_r = 1'b0;
`endif

    // k = (b mod 2**s) << (LOG2N-1-s)
    always_comb begin
        b_ext = LOG2N'(b_cnt);
        mask  = LOG2N'((1 << s_cnt) - 1);
        k_iss = (b_ext & mask) << (LOG2N - 1 - int'(s_cnt));
    end

    assign m_idx  = IW'(k_iss) & IW'(Q - 1);
    assign mc_idx = IW'(Q) - m_idx;

    twiddle_rom #(.WIDTH(WIDTH), .LOG2N(LOG2N)) u_rom (
        .clk    (clk),
        .rst    (rst),
        .en     (adv),
        .addr_a (m_idx),
        .addr_b (mc_idx),
        .data_a (c_m),
        .data_b (c_mc)
    );

    always_comb begin
        r_n = c_m;
        i_n = neg_w(c_mc);
        case (quadrant_t'(k1[LOG2N-1 -: 2]))
            QD0:     begin r_n = c_m;         i_n = neg_w(c_mc); end
            QD1:     begin r_n = neg_w(c_mc); i_n = neg_w(c_m);  end
            QD2:     begin r_n = neg_w(c_m);  i_n = c_mc;        end
            default: begin r_n = c_mc;        i_n = c_m;         end
        endcase
        if (inv_r) i_n = neg_w(i_n);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            k1       <= '0;
            s1       <= '0;
            last1    <= 1'b0;
            Rtw      <= '0;
            Itw      <= '0;
            k        <= '0;
            stage    <= '0;
            last     <= 1'b0;
        end else if (adv) begin
            vld_pipe <= {vld_pipe[STAGES-1:1], issue};
            k1       <= k_iss;
            s1       <= s_cnt;
            last1    <= issue && issue_last;
            Rtw      <= r_n;
            Itw      <= i_n;
            k        <= k1;
            stage    <= s1;
            last     <= last1 && vld_pipe[1];
        end
    end

endmodule
